// File: rtl/cmp_alarm_tracker.sv
// Hysteretic alarm tracker behind the 4-bit magnitude comparator.
// Counts gt/eq/lt outcomes, raises/clears alarm on sample streaks.
module cmp_alarm_tracker #(
    parameter int SET_COUNT = 3,
    parameter int CLR_COUNT = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    input  logic             clear,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] lt_count,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMING,
        S_ALARM,
        S_CLEARING
    } state_e;

    localparam logic [3:0]       SET_N   = 4'(SET_COUNT);
    localparam logic [3:0]       CLR_N   = 4'(CLR_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       run_inc;
    logic             alarm_q, alarm_d;
    logic             rise_q, fall_q, err_q;
    logic [CNT_W-1:0] gt_cnt_q, eq_cnt_q, lt_cnt_q;
    logic             legal;

    assign legal   = $onehot({gt, eq, lt});
    assign run_inc = run_q + 4'd1;

    // Next state assuming the current sample is legal
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            S_IDLE: begin
                if (gt) begin
                    if (SET_COUNT == 1) begin
                        state_d = S_ALARM;
                        run_d   = 4'd0;
                    end else begin
                        state_d = S_ARMING;
                        run_d   = 4'd1;
                    end
                end else begin
                    run_d = 4'd0;
                end
            end
            S_ARMING: begin
                if (gt) begin
                    if (run_inc == SET_N) begin
                        state_d = S_ALARM;
                        run_d   = 4'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end else begin
                    state_d = S_IDLE;
                    run_d   = 4'd0;
                end
            end
            S_ALARM: begin
                if (lt) begin
                    if (CLR_COUNT == 1) begin
                        state_d = S_IDLE;
                        run_d   = 4'd0;
                    end else begin
                        state_d = S_CLEARING;
                        run_d   = 4'd1;
                    end
                end else begin
                    run_d = 4'd0;
                end
            end
            S_CLEARING: begin
                if (lt) begin
                    if (run_inc == CLR_N) begin
                        state_d = S_IDLE;
                        run_d   = 4'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end else begin
                    state_d = S_ALARM;
                    run_d   = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                run_d   = 4'd0;
            end
        endcase
        alarm_d = (state_d == S_ALARM) || (state_d == S_CLEARING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            run_q    <= 4'd0;
            alarm_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            err_q    <= 1'b0;
            gt_cnt_q <= '0;
            eq_cnt_q <= '0;
            lt_cnt_q <= '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (clear) begin
                state_q  <= S_IDLE;
                run_q    <= 4'd0;
                alarm_q  <= 1'b0;
                fall_q   <= alarm_q;
                err_q    <= 1'b0;
                gt_cnt_q <= '0;
                eq_cnt_q <= '0;
                lt_cnt_q <= '0;
            end else if (in_valid) begin
                if (!legal) begin
                    err_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    run_q   <= run_d;
                    alarm_q <= alarm_d;
                    rise_q  <= !alarm_q && alarm_d;
                    fall_q  <= alarm_q && !alarm_d;
                    if (gt && gt_cnt_q != CNT_MAX) gt_cnt_q <= gt_cnt_q + CNT_ONE;
                    if (eq && eq_cnt_q != CNT_MAX) eq_cnt_q <= eq_cnt_q + CNT_ONE;
                    if (lt && lt_cnt_q != CNT_MAX) lt_cnt_q <= lt_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign alarm      = alarm_q;
    assign alarm_rise = rise_q;
    assign alarm_fall = fall_q;
    assign gt_count   = gt_cnt_q;
    assign eq_count   = eq_cnt_q;
    assign lt_count   = lt_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cmp_alarm_tracker.sv
// Directed bench for cmp_alarm_tracker: default instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation.
module tb_cmp_alarm_tracker;

    logic clk = 1'b0;
    logic rst_n, in_valid, gt, eq, lt, clear;

    logic       alarm, rise, fall, err;
    logic [7:0] gt_c, eq_c, lt_c;
    logic       s_alarm, s_rise, s_fall, s_err;
    logic [1:0] s_gt_c, s_eq_c, s_lt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_alarm_tracker u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .gt(gt), .eq(eq), .lt(lt), .clear(clear),
        .alarm(alarm), .alarm_rise(rise), .alarm_fall(fall),
        .gt_count(gt_c), .eq_count(eq_c), .lt_count(lt_c),
        .err(err)
    );

    cmp_alarm_tracker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .gt(gt), .eq(eq), .lt(lt), .clear(clear),
        .alarm(s_alarm), .alarm_rise(s_rise), .alarm_fall(s_fall),
        .gt_count(s_gt_c), .eq_count(s_eq_c), .lt_count(s_lt_c),
        .err(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge
    task automatic step(input logic v, input logic [2:0] gel,
                        input logic c);
        in_valid = v;
        {gt, eq, lt} = gel;
        clear = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        {gt, eq, lt} = 3'b000;
        clear = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic a, input logic r,
                           input logic f, input logic [7:0] g,
                           input logic [7:0] e, input logic [7:0] l,
                           input logic er);
        chk({tag, ".alarm"}, 32'(alarm), 32'(a));
        chk({tag, ".rise"}, 32'(rise), 32'(r));
        chk({tag, ".fall"}, 32'(fall), 32'(f));
        chk({tag, ".gt"}, 32'(gt_c), 32'(g));
        chk({tag, ".eq"}, 32'(eq_c), 32'(e));
        chk({tag, ".lt"}, 32'(lt_c), 32'(l));
        chk({tag, ".err"}, 32'(err), 32'(er));
    endtask

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        {gt, eq, lt} = 3'b000;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("rst", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (5) step(0, 3'b000, 0);
        chk_out("idle", 0, 0, 0, 0, 0, 0, 0);

        // Arm and assert
        step(1, GT, 0);
        chk_out("arm1", 0, 0, 0, 1, 0, 0, 0);
        step(1, GT, 0);
        chk_out("arm2", 0, 0, 0, 2, 0, 0, 0);
        step(1, GT, 0);
        chk_out("arm3", 1, 1, 0, 3, 0, 0, 0);
        step(0, 3'b000, 0);
        chk_out("hold", 1, 0, 0, 3, 0, 0, 0);

        // Soft clear out of ALARM
        step(0, 3'b000, 1);
        chk_out("clr1", 0, 0, 1, 0, 0, 0, 0);
        step(0, 3'b000, 0);
        chk_out("clr1b", 0, 0, 0, 0, 0, 0, 0);

        // Broken streak
        step(1, GT, 0);
        step(1, GT, 0);
        step(1, EQ, 0);
        step(1, GT, 0);
        step(1, GT, 0);
        chk_out("brk", 0, 0, 0, 4, 1, 0, 0);
        step(1, GT, 0);
        chk_out("brk_set", 1, 1, 0, 5, 1, 0, 0);

        // Hysteresis clear
        step(1, LT, 0);
        chk_out("hy_lt1", 1, 0, 0, 5, 1, 1, 0);
        step(1, GT, 0);
        chk_out("hy_gt", 1, 0, 0, 6, 1, 1, 0);
        step(1, LT, 0);
        chk_out("hy_lt2", 1, 0, 0, 6, 1, 2, 0);
        step(1, LT, 0);
        chk_out("hy_lt3", 0, 0, 1, 6, 1, 3, 0);
        step(0, 3'b000, 0);
        chk_out("hy_post", 0, 0, 0, 6, 1, 3, 0);

        // Illegal encodings mid-streak must not disturb the run
        step(1, GT, 0);
        chk_out("il_gt", 0, 0, 0, 7, 1, 3, 0);
        step(1, 3'b110, 0);
        chk_out("il_110", 0, 0, 0, 7, 1, 3, 1);
        step(1, 3'b000, 0);
        chk_out("il_000", 0, 0, 0, 7, 1, 3, 1);
        step(1, GT, 0);
        step(1, GT, 0);
        chk_out("il_set", 1, 1, 0, 9, 1, 3, 1);
        step(0, 3'b000, 1);
        chk_out("il_clr", 0, 0, 1, 0, 0, 0, 0);

        // Illegal sample alongside clear is discarded
        step(1, 3'b111, 1);
        chk_out("clr_ill", 0, 0, 0, 0, 0, 0, 0);

        // Saturation on the narrow instance
        repeat (5) step(1, EQ, 0);
        chk("sat.eq", 32'(s_eq_c), 32'd3);
        chk("wide.eq", 32'(eq_c), 32'd5);
        chk("sat.err", 32'(s_err), 32'd0);
        repeat (3) step(1, GT, 0);
        chk("sat.alarm", 32'(s_alarm), 32'd1);
        chk("sat.gt", 32'(s_gt_c), 32'd3);
        step(1, GT, 0);
        chk("sat.gt_hold", 32'(s_gt_c), 32'd3);

        // Clear beats a same-cycle valid gt
        step(1, GT, 1);
        chk_out("prio", 0, 0, 1, 0, 0, 0, 0);
        chk("sat.prio_gt", 32'(s_gt_c), 32'd0);
        chk("sat.prio_eq", 32'(s_eq_c), 32'd0);
        chk("sat.prio_fall", 32'(s_fall), 32'd1);

        // Asynchronous reset while in ALARM
        repeat (3) step(1, GT, 0);
        chk("pre_rst.alarm", 32'(alarm), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("arst.fall", 32'(fall), 32'd0);
        rst_n = 1'b1;
        step(0, 3'b000, 0);
        chk_out("arst_rel", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_alarm_tracker.md
Name: cmp_alarm_tracker

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Samples its gt/eq/lt result on a valid strobe. Raises a hysteretic alarm after SET_COUNT consecutive "greater-than" results and clears it after CLR_COUNT consecutive "less-than" results.
- Keeps saturating event counters per outcome.
- Flags illegal (non-one-hot) comparator encodings.

Parameters:
- SET_COUNT, 3, consecutive valid gt samples needed to assert alarm (legal range 1..15)
- CLR_COUNT, 2, consecutive valid lt samples needed to deassert alarm (legal range 1..15)
- CNT_W, 8, width of each event counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  gt/eq/lt are sampled on this cycle
- gt  input  1  comparator a>b
- eq  input  1  comparator a==b
- lt  input  1  comparator a<b
- clear  input  1  synchronous soft clear of FSM, counters and err
- alarm  output  1  registered alarm level
- alarm_rise  output  1  one-cycle pulse on the cycle alarm goes 0->1
- alarm_fall  output  1  one-cycle pulse on the cycle alarm goes 1->0
- gt_count  output  CNT_W  valid gt samples seen, saturating
- eq_count  output  CNT_W  valid eq samples seen, saturating
- lt_count  output  CNT_W  valid lt samples seen, saturating
- err  output  1  sticky: a valid sample had an illegal encoding

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), no synchronizer inside the block.
- On rst_n=0: state=IDLE, run counter=0. All outputs are 0: alarm, alarm_rise, alarm_fall, err, and all three counts.
- All outputs are registered. The response to a sample accepted at edge k is visible after edge k, so latency is 1 cycle.
- Legal sample: in_valid=1 and exactly one of gt/eq/lt high.
- Illegal sample: in_valid=1 with zero or more than one of gt/eq/lt high. It sets err=1 (sticky) and does not change FSM, run counter or any count.
- in_valid=0: everything holds. Pulses return to 0.
- Counters: a legal sample increments the matching count by 1. A count at 2^CNT_W-1 holds (no wrap).
- Run counter: 4 bits, tracks consecutive qualifying samples in the current state.
- FSM states: IDLE, ARMING, ALARM, CLEARING. alarm=1 in ALARM and CLEARING, otherwise 0.
- IDLE:
  - legal gt: run=1, go to ARMING; go straight to ALARM if SET_COUNT==1.
  - eq or lt: stay, run=0.
- ARMING:
  - legal gt: run+1; if run+1==SET_COUNT, go to ALARM with run=0.
  - eq or lt: go to IDLE, run=0. A non-gt result breaks the streak.
- ALARM:
  - legal lt: run=1, go to CLEARING; go straight to IDLE if CLR_COUNT==1.
  - gt or eq: stay, run=0.
- CLEARING:
  - legal lt: run+1; if run+1==CLR_COUNT, go to IDLE with run=0.
  - gt or eq: return to ALARM, run=0. alarm stays 1 throughout, with no pulses.
- Pulses:
  - alarm_rise=1 for exactly the cycle after the edge where alarm changes 0->1.
  - alarm_fall=1 for exactly the cycle after the edge where alarm changes 1->0.
  - Never both high.
- clear=1 at an edge:
  - state=IDLE, run=0, counts=0, err=0.
  - Takes priority over a same-cycle in_valid; that sample is discarded, including for err.
  - If alarm was 1, alarm_fall pulses.
- Reset mid-operation: immediate asynchronous return to the reset values above. No pulse is generated.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no in_valid for 5 cycles -> all outputs 0, state IDLE.
- Arm and assert (SET_COUNT=3): valid gt,gt,gt on consecutive cycles -> alarm=1 one cycle after the 3rd sample, alarm_rise high for exactly that cycle, gt_count=3.
- Broken streak: gt,gt,eq,gt,gt -> alarm stays 0, eq_count=1, gt_count=4. One more gt -> alarm=1.
- Hysteresis clear (CLR_COUNT=2): from ALARM send lt,gt,lt,lt -> alarm stays 1 through lt,gt,lt. It drops after the final lt with alarm_fall pulsing once. lt_count=3.
- Illegal encodings: valid with {gt,eq,lt}=3'b110, then 3'b000 -> err=1 and stays 1, all counts unchanged, FSM unchanged. clear -> err=0.
- Saturation and priority: CNT_W=2, send 5 valid eq -> eq_count=3. In ALARM, assert clear with valid gt the same cycle -> counts 0, alarm_fall pulse, gt_count remains 0.
